// File: rtl/exe_stage.sv
// EXE stage of the 5-stage ARM pipeline: operand forwarding, shifter operand (Val2),
// ALU with status register, branch target, and the EX/MEM pipeline register.
module exe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             freeze,
  input  logic             WB_EN_In,
  input  logic             MEM_R_EN_In,
  input  logic             MEM_W_EN_In,
  input  logic             B_In,
  input  logic             S_In,
  input  logic [3:0]       EXE_CMD_In,
  input  logic [WIDTH-1:0] PC_In,
  input  logic [WIDTH-1:0] Val_Rn_In,
  input  logic [WIDTH-1:0] Val_Rm_In,
  input  logic             imm_In,
  input  logic [11:0]      Shift_operand_In,
  input  logic [23:0]      Signed_imm_24_In,
  input  logic [3:0]       Dest_In,
  input  logic [1:0]       Fwd_Sel_1,
  input  logic [1:0]       Fwd_Sel_2,
  input  logic [WIDTH-1:0] MEM_ALU_Res,
  input  logic [WIDTH-1:0] WB_Value,
  output logic             Br_taken,
  output logic [WIDTH-1:0] Br_addr,
  output logic [3:0]       SR,
  output logic             WB_EN_Out,
  output logic             MEM_R_EN_Out,
  output logic             MEM_W_EN_Out,
  output logic [WIDTH-1:0] ALU_Res_Out,
  output logic [WIDTH-1:0] Val_Rm_Out,
  output logic [3:0]       Dest_Out
);

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } aluCmd_e;

  logic [3:0]         sr_q, sr_d;
  logic               wbEn_q, memREn_q, memWEn_q;
  logic [WIDTH-1:0]   aluRes_q, valRm_q;
  logic [3:0]         dest_q;

  logic [WIDTH-1:0]   opA, opRm, val2, aluRes;
  logic [2*WIDTH-1:0] rotTmp;
  logic [WIDTH:0]     sum;
  logic               cIn, cOut, vOut;
  logic [4:0]         shAmt;
  aluCmd_e            aluCmd;

  assign Br_taken = B_In;
  assign Br_addr  = PC_In + {{(WIDTH-26){Signed_imm_24_In[23]}}, Signed_imm_24_In, 2'b00};

  always_comb begin
    case (Fwd_Sel_1)
      2'b01:   opA = MEM_ALU_Res;
      2'b10:   opA = WB_Value;
      default: opA = Val_Rn_In;
    endcase
    case (Fwd_Sel_2)
      2'b01:   opRm = MEM_ALU_Res;
      2'b10:   opRm = WB_Value;
      default: opRm = Val_Rm_In;
    endcase
  end

  // Loads/stores take a signed 12-bit offset regardless of the I bit.
  always_comb begin
    val2   = opRm;
    rotTmp = '0;
    shAmt  = '0;
    if (MEM_R_EN_In || MEM_W_EN_In) begin
      val2 = {{(WIDTH-12){Shift_operand_In[11]}}, Shift_operand_In};
    end else if (imm_In) begin
      shAmt  = {Shift_operand_In[11:8], 1'b0};
      rotTmp = {{(WIDTH-8){1'b0}}, Shift_operand_In[7:0],
                {(WIDTH-8){1'b0}}, Shift_operand_In[7:0]} >> shAmt;
      val2   = rotTmp[WIDTH-1:0];
    end else begin
      shAmt = Shift_operand_In[11:7];
      case (Shift_operand_In[6:5])
        2'b00: val2 = opRm << shAmt;
        2'b01: val2 = opRm >> shAmt;
        2'b10: val2 = WIDTH'($signed(opRm) >>> shAmt);
        default: begin
          rotTmp = {opRm, opRm} >> shAmt;
          val2   = rotTmp[WIDTH-1:0];
        end
      endcase
    end
  end

  assign cIn    = sr_q[1];
  assign aluCmd = aluCmd_e'(EXE_CMD_In);

  // Logical ops and unknown codes keep the previous C and V.
  always_comb begin
    aluRes = '0;
    sum    = '0;
    cOut   = sr_q[1];
    vOut   = sr_q[0];
    case (aluCmd)
      CMD_MOV: aluRes = val2;
      CMD_MVN: aluRes = ~val2;
      CMD_ADD, CMD_ADC: begin
        sum    = {1'b0, opA} + {1'b0, val2}
                 + {{WIDTH{1'b0}}, (aluCmd == CMD_ADC) & cIn};
        aluRes = sum[WIDTH-1:0];
        cOut   = sum[WIDTH];
        vOut   = (opA[WIDTH-1] == val2[WIDTH-1]) && (aluRes[WIDTH-1] != opA[WIDTH-1]);
      end
      CMD_SUB, CMD_SBC: begin
        sum    = {1'b0, opA} - {1'b0, val2}
                 - {{WIDTH{1'b0}}, (aluCmd == CMD_SBC) & ~cIn};
        aluRes = sum[WIDTH-1:0];
        cOut   = ~sum[WIDTH];
        vOut   = (opA[WIDTH-1] != val2[WIDTH-1]) && (aluRes[WIDTH-1] != opA[WIDTH-1]);
      end
      CMD_AND: aluRes = opA & val2;
      CMD_ORR: aluRes = opA | val2;
      CMD_EOR: aluRes = opA ^ val2;
      default: aluRes = '0;
    endcase
    sr_d = {aluRes[WIDTH-1], (aluRes == '0), cOut, vOut};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sr_q <= '0;
    end else if (S_In && !freeze) begin
      sr_q <= sr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wbEn_q   <= 1'b0;
      memREn_q <= 1'b0;
      memWEn_q <= 1'b0;
      aluRes_q <= '0;
      valRm_q  <= '0;
      dest_q   <= '0;
    end else if (!freeze) begin
      wbEn_q   <= WB_EN_In;
      memREn_q <= MEM_R_EN_In;
      memWEn_q <= MEM_W_EN_In;
      aluRes_q <= aluRes;
      valRm_q  <= opRm;
      dest_q   <= Dest_In;
    end
  end

  assign SR           = sr_q;
  assign WB_EN_Out    = wbEn_q;
  assign MEM_R_EN_Out = memREn_q;
  assign MEM_W_EN_Out = memWEn_q;
  assign ALU_Res_Out  = aluRes_q;
  assign Val_Rm_Out   = valRm_q;
  assign Dest_Out     = dest_q;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: a driver pushes the model's expected EX/MEM+SR state
// each cycle; a monitor pops and compares after every rising edge.
module tb_exe_stage;

  logic        CLK = 1'b0;
  logic        RST, freeze, WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, B_In, S_In, imm_In;
  logic [3:0]  EXE_CMD_In, Dest_In;
  logic [31:0] PC_In, Val_Rn_In, Val_Rm_In, MEM_ALU_Res, WB_Value;
  logic [11:0] Shift_operand_In;
  logic [23:0] Signed_imm_24_In;
  logic [1:0]  Fwd_Sel_1, Fwd_Sel_2;
  logic        Br_taken, WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out;
  logic [31:0] Br_addr, ALU_Res_Out, Val_Rm_Out;
  logic [3:0]  SR, Dest_Out;

  typedef struct packed {
    logic        rst, frz, wb, mr, mw, b, s, imm;
    logic [3:0]  cmd, dest;
    logic [31:0] pc, rn, rm, memRes, wbVal;
    logic [11:0] shop;
    logic [23:0] simm;
    logic [1:0]  f1, f2;
  } stim_t;

  typedef struct packed {
    logic        wb, mr, mw;
    logic [31:0] alu, rm;
    logic [3:0]  dest, sr;
  } out_t;

  out_t mState = '0;
  out_t expQ[$];
  int   total = 0;
  int   bad = 0;

  exe_stage #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .freeze(freeze),
    .WB_EN_In(WB_EN_In), .MEM_R_EN_In(MEM_R_EN_In), .MEM_W_EN_In(MEM_W_EN_In),
    .B_In(B_In), .S_In(S_In), .EXE_CMD_In(EXE_CMD_In), .PC_In(PC_In),
    .Val_Rn_In(Val_Rn_In), .Val_Rm_In(Val_Rm_In), .imm_In(imm_In),
    .Shift_operand_In(Shift_operand_In), .Signed_imm_24_In(Signed_imm_24_In),
    .Dest_In(Dest_In), .Fwd_Sel_1(Fwd_Sel_1), .Fwd_Sel_2(Fwd_Sel_2),
    .MEM_ALU_Res(MEM_ALU_Res), .WB_Value(WB_Value),
    .Br_taken(Br_taken), .Br_addr(Br_addr), .SR(SR),
    .WB_EN_Out(WB_EN_Out), .MEM_R_EN_Out(MEM_R_EN_Out), .MEM_W_EN_Out(MEM_W_EN_Out),
    .ALU_Res_Out(ALU_Res_Out), .Val_Rm_Out(Val_Rm_Out), .Dest_Out(Dest_Out)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] pickSrc(logic [1:0] sel, logic [31:0] base, logic [31:0] mem, logic [31:0] wbv);
    if (sel == 2'd1) return mem;
    if (sel == 2'd2) return wbv;
    return base;
  endfunction

  // Shifts modelled one bit position at a time.
  function automatic logic [31:0] shiftBy(logic [31:0] x, int n, int kind);
    for (int i = 0; i < n; i++) begin
      case (kind)
        0: x = {x[30:0], 1'b0};
        1: x = {1'b0, x[31:1]};
        2: x = {x[31], x[31:1]};
        default: x = {x[0], x[31:1]};
      endcase
    end
    return x;
  endfunction

  function automatic logic [31:0] randVal();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h7FFFFFFF;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic void modelStep(stim_t s);
    logic [31:0] a, rmF, v2, res;
    logic        c, v, cin;
    longint      u, sres, k, offs;
    if (s.rst) begin
      mState = '0;
      return;
    end
    a   = pickSrc(s.f1, s.rn, s.memRes, s.wbVal);
    rmF = pickSrc(s.f2, s.rm, s.memRes, s.wbVal);
    if (s.mr || s.mw) begin
      offs = longint'(s.shop);
      if (offs >= 2048) offs = offs - 4096;
      v2 = offs[31:0];
    end else if (s.imm) begin
      v2 = shiftBy({24'h0, s.shop[7:0]}, 2 * int'(s.shop[11:8]), 3);
    end else begin
      v2 = shiftBy(rmF, int'(s.shop[11:7]), int'(s.shop[6:5]));
    end
    cin = mState.sr[1];
    c = mState.sr[1];
    v = mState.sr[0];
    res = 32'h0;
    case (s.cmd)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd2, 4'd3: begin
        k    = (s.cmd == 4'd3 && cin) ? 1 : 0;
        u    = longint'(a) + longint'(v2) + k;
        sres = longint'($signed(a)) + longint'($signed(v2)) + k;
        res  = u[31:0];
        c    = (u >= 64'sd4294967296);
        v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        k    = (s.cmd == 4'd5 && !cin) ? 1 : 0;
        u    = longint'(a) - longint'(v2) - k;
        sres = longint'($signed(a)) - longint'($signed(v2)) - k;
        res  = u[31:0];
        c    = (u >= 0);
        v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      4'd6: res = a & v2;
      4'd7: res = a | v2;
      4'd8: res = a ^ v2;
      default: res = 32'h0;
    endcase
    if (!s.frz) begin
      mState.wb   = s.wb;
      mState.mr   = s.mr;
      mState.mw   = s.mw;
      mState.alu  = res;
      mState.rm   = rmF;
      mState.dest = s.dest;
      if (s.s) mState.sr = {res[31], res == 32'h0, c, v};
    end
  endfunction

  task automatic applyStimulus(input stim_t s);
    longint off;
    logic [31:0] brExp;
    @(negedge CLK);
    RST = s.rst; freeze = s.frz; WB_EN_In = s.wb; MEM_R_EN_In = s.mr; MEM_W_EN_In = s.mw;
    B_In = s.b; S_In = s.s; imm_In = s.imm; EXE_CMD_In = s.cmd; Dest_In = s.dest;
    PC_In = s.pc; Val_Rn_In = s.rn; Val_Rm_In = s.rm; MEM_ALU_Res = s.memRes;
    WB_Value = s.wbVal; Shift_operand_In = s.shop; Signed_imm_24_In = s.simm;
    Fwd_Sel_1 = s.f1; Fwd_Sel_2 = s.f2;
    modelStep(s);
    expQ.push_back(mState);
    off = longint'(s.simm);
    if (off >= 64'sd8388608) off = off - 64'sd16777216;
    off = longint'(s.pc) + off * 4;
    brExp = off[31:0];
    #1;
    checkOutput("branch", {47'h0, Br_taken, Br_addr}, {47'h0, s.b, brExp});
  endtask

  function automatic stim_t randStim();
    stim_t s;
    s = '0;
    s.rst = ($urandom_range(0, 39) == 0);
    s.frz = ($urandom_range(0, 4) == 0);
    s.wb = $urandom_range(0, 1); s.mr = ($urandom_range(0, 5) == 0); s.mw = ($urandom_range(0, 5) == 0);
    s.b = $urandom_range(0, 1); s.s = $urandom_range(0, 1); s.imm = $urandom_range(0, 1);
    s.cmd = 4'($urandom_range(0, 15)); s.dest = 4'($urandom);
    s.pc = $urandom; s.rn = randVal(); s.rm = randVal(); s.memRes = randVal(); s.wbVal = randVal();
    s.shop = 12'($urandom); s.simm = 24'($urandom);
    s.f1 = 2'($urandom); s.f2 = 2'($urandom);
    return s;
  endfunction

  always @(posedge CLK) begin
    out_t exp, act;
    #1;
    if (expQ.size() > 0) begin
      exp = expQ.pop_front();
      act = {WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out, ALU_Res_Out, Val_Rm_Out, Dest_Out, SR};
      checkOutput("exmem_sr", {5'h0, act}, {5'h0, exp});
    end
  end

  initial begin
    stim_t st;
    RST = 1'b1; freeze = 1'b0; WB_EN_In = 1'b0; MEM_R_EN_In = 1'b0; MEM_W_EN_In = 1'b0;
    B_In = 1'b0; S_In = 1'b0; imm_In = 1'b0; EXE_CMD_In = '0; Dest_In = '0;
    PC_In = '0; Val_Rn_In = '0; Val_Rm_In = '0; MEM_ALU_Res = '0; WB_Value = '0;
    Shift_operand_In = '0; Signed_imm_24_In = '0; Fwd_Sel_1 = '0; Fwd_Sel_2 = '0;

    for (int i = 0; i < 2; i++) begin
      st = randStim(); st.rst = 1'b1;
      applyStimulus(st);
    end
    @(posedge CLK); #2;
    checkOutput("reset_state", {5'h0, WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out, ALU_Res_Out, Val_Rm_Out, Dest_Out, SR}, 80'h0);

    st = '0; st.cmd = 4'd2; st.s = 1'b1; st.rn = 32'h7FFFFFFF; st.imm = 1'b1; st.shop = 12'h001; st.wb = 1'b1; st.dest = 4'd3;
    applyStimulus(st);
    @(posedge CLK); #2;
    checkOutput("add_ovf", {44'h0, SR, ALU_Res_Out}, {44'h0, 4'b1001, 32'h80000000});

    st = '0; st.cmd = 4'd4; st.s = 1'b1; st.rn = 32'd5; st.rm = 32'd5;
    applyStimulus(st);
    @(posedge CLK); #2;
    checkOutput("sub_zero", {44'h0, SR, ALU_Res_Out}, {44'h0, 4'b0110, 32'h0});

    st = '0; st.cmd = 4'd3; st.rn = 32'd1; st.imm = 1'b1; st.shop = 12'h001;
    applyStimulus(st);
    @(posedge CLK); #2;
    checkOutput("adc_cin", {48'h0, ALU_Res_Out}, {48'h0, 32'd3});

    st = '0; st.cmd = 4'd1; st.imm = 1'b1; st.shop = 12'h4FF;
    applyStimulus(st);
    @(posedge CLK); #2;
    checkOutput("mov_rot", {48'h0, ALU_Res_Out}, {48'h0, 32'hFF000000});

    st = '0; st.cmd = 4'd1; st.rm = 32'h80000000; st.shop = 12'h220;
    applyStimulus(st);
    @(posedge CLK); #2;
    checkOutput("lsr4", {48'h0, ALU_Res_Out}, {48'h0, 32'h08000000});

    st.shop = 12'h240;
    applyStimulus(st);
    @(posedge CLK); #2;
    checkOutput("asr4", {48'h0, ALU_Res_Out}, {48'h0, 32'hF8000000});

    st.rm = 32'h12345678; st.shop = 12'h460;
    applyStimulus(st);
    @(posedge CLK); #2;
    checkOutput("ror8", {48'h0, ALU_Res_Out}, {48'h0, 32'h78123456});

    st = '0; st.cmd = 4'd2; st.f1 = 2'b01; st.memRes = 32'd10; st.f2 = 2'b10; st.wbVal = 32'd20;
    st.rn = 32'd777; st.rm = 32'd888;
    applyStimulus(st);
    @(posedge CLK); #2;
    checkOutput("fwd_add", {48'h0, ALU_Res_Out}, {48'h0, 32'd30});

    st = '0; st.cmd = 4'd2; st.mw = 1'b1; st.rn = 32'd100; st.rm = 32'd999; st.f2 = 2'b10;
    st.wbVal = 32'd20; st.shop = 12'hFFC;
    applyStimulus(st);
    @(posedge CLK); #2;
    checkOutput("str_addr", {15'h0, MEM_W_EN_Out, ALU_Res_Out, Val_Rm_Out}, {15'h0, 1'b1, 32'd96, 32'd20});

    st = '0; st.b = 1'b1; st.pc = 32'h100; st.simm = 24'hFFFFFE;
    applyStimulus(st);
    checkOutput("br_target", {47'h0, Br_taken, Br_addr}, {47'h0, 1'b1, 32'h000000F8});

    for (int i = 0; i < 3; i++) begin
      st = randStim(); st.rst = 1'b0; st.frz = 1'b1; st.s = 1'b1; st.cmd = 4'd4;
      applyStimulus(st);
    end
    @(posedge CLK); #2;
    checkOutput("freeze_hold", {44'h0, SR, ALU_Res_Out}, {44'h0, 4'b0110, 32'h0});

    st = '0;
    applyStimulus(st);
    @(posedge CLK); #2;
    checkOutput("bubble", {5'h0, WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out, ALU_Res_Out, Val_Rm_Out, Dest_Out, SR},
                {5'h0, 3'b000, 32'h0, 32'h0, 4'h0, 4'b0110});

    for (int i = 0; i < 500; i++) begin
      applyStimulus(randStim());
    end

    repeat (3) @(posedge CLK);
    #3;
    checkOutput("queue_drained", 80'(expQ.size()), 80'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
